zeroriscy_trace_encoder: RTL and testbench

ZERORISCY_TRACE_ENCODER -- requirements
Module: zeroriscy_trace_encoder

---
 rtl/zeroriscy_trace_encoder_if.sv | 45 ++++
 rtl/zeroriscy_trace_encoder.sv | 210 +++++++++++++++++++++
 tb/tb_zeroriscy_trace_encoder.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/zeroriscy_trace_encoder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : zeroriscy_trace_encoder_if
//  Description : Retire-event capture bus and trace word stream between the
//                core, the trace encoder and the trace sink.
//  Revision    : 1.0 - initial release
// ============================================================================
interface zeroriscy_trace_encoder_if;
    // Retire event side
    logic        trace_en;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic [31:0] retire_instr;
    logic        retire_rd_we;
    logic [4:0]  retire_rd_addr;
    logic [31:0] retire_rd_wdata;
    logic        retire_mem_en;
    logic [31:0] retire_mem_addr;
    // Trace word stream side
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] tx_data;
    logic        tx_last;
    // Status
    logic [15:0] drop_cnt;
    logic [4:0]  fifo_level;

    // Driver of retire events and consumer of trace words
    modport master (
        output trace_en, retire_valid, retire_pc, retire_instr, retire_rd_we,
               retire_rd_addr, retire_rd_wdata, retire_mem_en, retire_mem_addr,
               tx_ready,
        input  tx_valid, tx_data, tx_last, drop_cnt, fifo_level
    );

    // The encoder itself
    modport slave (
        input  trace_en, retire_valid, retire_pc, retire_instr, retire_rd_we,
               retire_rd_addr, retire_rd_wdata, retire_mem_en, retire_mem_addr,
               tx_ready,
        output tx_valid, tx_data, tx_last, drop_cnt, fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/zeroriscy_trace_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : zeroriscy_trace_encoder
//  Description : Captures retired-instruction records into a small FIFO and
//                serializes each record as a 3..5 word trace packet
//                (HDR, PC, INSTR, optional RD, optional MEM).
//  Revision    : 1.0 - initial release
// ============================================================================
module zeroriscy_trace_encoder #(
    parameter int FIFO_DEPTH = 4    // power of two, 2..16
) (
    input  wire logic clk,
    input  wire logic rst,
    zeroriscy_trace_encoder_if.slave bus
);

    localparam int         c_PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] c_DEPTH_LVL = 5'(FIFO_DEPTH);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_HDR   = 3'd1;
    localparam logic [2:0] c_ST_PC    = 3'd2;
    localparam logic [2:0] c_ST_INSTR = 3'd3;
    localparam logic [2:0] c_ST_RD    = 3'd4;
    localparam logic [2:0] c_ST_MEM   = 3'd5;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rd_flag;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic        mem_en;
        logic [31:0] mem_addr;
        logic [7:0]  seq;
        logic [8:0]  drops;
    } rec_t;

    rec_t               r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [4:0]         r_level;
    logic [7:0]         r_seq;
    logic [8:0]         r_pending_drops;
    logic [15:0]        r_drop_cnt;
    logic [2:0]         r_state;

    logic               w_capture;
    logic               w_full;
    logic               w_push;
    logic               w_drop;
    logic               w_hs;
    logic               w_last;
    logic               w_pop;
    logic [2:0]         w_end_state;
    logic [2:0]         w_state_nxt;
    logic [31:0]        w_data;
    rec_t               w_new_rec;
    rec_t               w_head;

    // Full is judged on the registered level, so a same-cycle pop never
    // makes room for a push.
    assign w_capture = bus.retire_valid && bus.trace_en;
    assign w_full    = (r_level == c_DEPTH_LVL);
    assign w_push    = w_capture && !w_full;
    assign w_drop    = w_capture && w_full;
    assign w_hs      = (r_state != c_ST_IDLE) && bus.tx_ready;
    assign w_pop     = w_hs && w_last;
    assign w_head    = r_fifo[r_rd_ptr];

    assign w_new_rec = '{
        pc:       bus.retire_pc,
        instr:    bus.retire_instr,
        rd_flag:  bus.retire_rd_we && (bus.retire_rd_addr != 5'd0),
        rd_addr:  bus.retire_rd_addr,
        rd_wdata: bus.retire_rd_wdata,
        mem_en:   bus.retire_mem_en,
        mem_addr: bus.retire_mem_addr,
        seq:      r_seq,
        drops:    r_pending_drops
    };

    // Record storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_new_rec;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= 5'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 5'd1;
                2'b01:   r_level <= r_level - 5'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sequence number and drop accounting; drops since the last accepted
    // record ride along in that next record's header
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq           <= 8'd0;
            r_pending_drops <= 9'd0;
            r_drop_cnt      <= 16'd0;
        end else begin
            if (w_push) begin
                r_seq           <= r_seq + 8'd1;
                r_pending_drops <= 9'd0;
            end else if (w_drop) begin
                if (r_pending_drops != 9'h1FF) begin
                    r_pending_drops <= r_pending_drops + 9'd1;
                end
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // Serializer next state; a finished record chains straight into the
    // next header when another record is already queued behind it
    always_comb begin
        w_end_state = (r_level > 5'd1) ? c_ST_HDR : c_ST_IDLE;
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (r_level != 5'd0) w_state_nxt = c_ST_HDR;
            end
            c_ST_HDR: begin
                if (w_hs) w_state_nxt = c_ST_PC;
            end
            c_ST_PC: begin
                if (w_hs) w_state_nxt = c_ST_INSTR;
            end
            c_ST_INSTR: begin
                if (w_hs) begin
                    if (w_head.rd_flag)     w_state_nxt = c_ST_RD;
                    else if (w_head.mem_en) w_state_nxt = c_ST_MEM;
                    else                    w_state_nxt = w_end_state;
                end
            end
            c_ST_RD: begin
                if (w_hs) w_state_nxt = w_head.mem_en ? c_ST_MEM : w_end_state;
            end
            c_ST_MEM: begin
                if (w_hs) w_state_nxt = w_end_state;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Serializer state register; reset abandons any partial record
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Word and last-flag selection purely from state and FIFO head, so both
    // hold steady while the sink stalls
    always_comb begin
        w_data = 32'd0;
        w_last = 1'b0;
        case (r_state)
            c_ST_HDR:   w_data = {8'hA5, w_head.seq, w_head.rd_flag, w_head.mem_en,
                                  w_head.rd_addr, w_head.drops};
            c_ST_PC:    w_data = w_head.pc;
            c_ST_INSTR: begin
                w_data = w_head.instr;
                w_last = !w_head.rd_flag && !w_head.mem_en;
            end
            c_ST_RD: begin
                w_data = w_head.rd_wdata;
                w_last = !w_head.mem_en;
            end
            c_ST_MEM: begin
                w_data = w_head.mem_addr;
                w_last = 1'b1;
            end
            default: begin
                w_data = 32'd0;
                w_last = 1'b0;
            end
        endcase
    end

    assign bus.tx_valid   = (r_state != c_ST_IDLE);
    assign bus.tx_data    = w_data;
    assign bus.tx_last    = w_last;
    assign bus.drop_cnt   = r_drop_cnt;
    assign bus.fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_zeroriscy_trace_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_zeroriscy_trace_encoder
//  Description : Directed self-checking bench for zeroriscy_trace_encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_zeroriscy_trace_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    zeroriscy_trace_encoder_if ifc ();

    zeroriscy_trace_encoder #(.FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] words [$];   // {last, data} of every accepted word
    logic [32:0] exp_q [$];
    logic        stall_chk = 1'b0;
    logic        prev_stall = 1'b0;
    logic [33:0] prev_word = '0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Collect accepted words away from the active edge
    always @(negedge clk) begin
        if (!rst && ifc.tx_valid && ifc.tx_ready) words.push_back({ifc.tx_last, ifc.tx_data});
    end

    // While stalled, valid/last/data must not move
    always @(negedge clk) begin
        if (stall_chk && prev_stall)
            check_eq("stall_hold", 64'({ifc.tx_valid, ifc.tx_last, ifc.tx_data}), 64'(prev_word));
        prev_stall = !rst && ifc.tx_valid && !ifc.tx_ready;
        prev_word  = {ifc.tx_valid, ifc.tx_last, ifc.tx_data};
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_retire();
        ifc.retire_valid    = 1'b0;
        ifc.retire_pc       = 32'd0;
        ifc.retire_instr    = 32'd0;
        ifc.retire_rd_we    = 1'b0;
        ifc.retire_rd_addr  = 5'd0;
        ifc.retire_rd_wdata = 32'd0;
        ifc.retire_mem_en   = 1'b0;
        ifc.retire_mem_addr = 32'd0;
    endtask

    task automatic set_retire(input logic [31:0] pc, input logic [31:0] instr, input logic rd_we,
                              input logic [4:0] rd, input logic [31:0] wdata,
                              input logic mem_en, input logic [31:0] maddr);
        ifc.retire_valid    = 1'b1;
        ifc.retire_pc       = pc;
        ifc.retire_instr    = instr;
        ifc.retire_rd_we    = rd_we;
        ifc.retire_rd_addr  = rd;
        ifc.retire_rd_wdata = wdata;
        ifc.retire_mem_en   = mem_en;
        ifc.retire_mem_addr = maddr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        words.delete();
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (ifc.fifo_level == 5'd0 && !ifc.tx_valid) break;
            tick();
        end
        if (i == budget) check_eq("wait_idle_timeout", 64'({ifc.tx_valid, ifc.fifo_level}), 64'd0);
    endtask

    task automatic ew(input logic last, input logic [31:0] d);
        exp_q.push_back({last, d});
    endtask

    task automatic check_words(input string tag);
        check_eq({tag, "_count"}, 64'(words.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < words.size()) check_eq($sformatf("%s_w%0d", tag, i), 64'(words[i]), 64'(exp_q[i]));
        end
        exp_q.delete();
    endtask

    initial begin
        ifc.trace_en = 1'b1;
        ifc.tx_ready = 1'b1;
        // Retire pending while reset is held: reset must win
        set_retire(32'h40, 32'h13, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        rst = 1'b1;
        tick();
        check_eq("rst_tx_valid", 64'(ifc.tx_valid), 64'd0);
        check_eq("rst_tx_last", 64'(ifc.tx_last), 64'd0);
        check_eq("rst_tx_data", 64'(ifc.tx_data), 64'd0);
        check_eq("rst_fifo_level", 64'(ifc.fifo_level), 64'd0);
        check_eq("rst_drop_cnt", 64'(ifc.drop_cnt), 64'd0);
        clear_retire();
        do_reset();

        // Single ADD x3: latency and 4-word record
        set_retire(32'h80, 32'h002081B3, 1'b1, 5'd3, 32'h5, 1'b0, 32'd0);
        tick();
        check_eq("add_level_after_push", 64'(ifc.fifo_level), 64'd1);
        check_eq("add_valid_edge_n", 64'(ifc.tx_valid), 64'd0);
        clear_retire();
        tick();
        check_eq("add_valid_edge_n1", 64'(ifc.tx_valid), 64'd1);
        check_eq("add_hdr_first", 64'(ifc.tx_data), 64'hA5008600);
        wait_idle(50);
        ew(1'b0, 32'hA5008600); ew(1'b0, 32'h80); ew(1'b0, 32'h002081B3); ew(1'b1, 32'h5);
        check_words("add");

        // SW: memory word only
        do_reset();
        set_retire(32'h84, 32'h0020A023, 1'b0, 5'd0, 32'd0, 1'b1, 32'h1000);
        tick();
        clear_retire();
        wait_idle(50);
        ew(1'b0, 32'hA5004000); ew(1'b0, 32'h84); ew(1'b0, 32'h0020A023); ew(1'b1, 32'h1000);
        check_words("sw");

        // Overflow: 6 retires into a stalled depth-4 FIFO
        do_reset();
        ifc.tx_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            set_retire(32'h200 + 32'(k * 4), 32'h13, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
            tick();
        end
        clear_retire();
        check_eq("ovf_level", 64'(ifc.fifo_level), 64'd4);
        check_eq("ovf_drop_cnt", 64'(ifc.drop_cnt), 64'd2);
        ifc.tx_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (ifc.fifo_level == 5'd3) break;
            tick();
        end
        check_eq("ovf_level_after_pop", 64'(ifc.fifo_level), 64'd3);
        set_retire(32'h300, 32'h13, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        tick();
        clear_retire();
        wait_idle(100);
        check_eq("ovf_word_count", 64'(words.size()), 64'd15);
        if (words.size() == 15) begin
            check_eq("ovf_hdr0", 64'(words[0]), 64'({1'b0, 32'hA5000000}));
            check_eq("ovf_hdr1", 64'(words[3]), 64'({1'b0, 32'hA5010000}));
            check_eq("ovf_hdr4", 64'(words[12]), 64'({1'b0, 32'hA5040002}));
            check_eq("ovf_pc4", 64'(words[13]), 64'({1'b0, 32'h300}));
            check_eq("ovf_last", 64'(words[14]), 64'({1'b1, 32'h13}));
        end
        check_eq("ovf_drop_cnt_final", 64'(ifc.drop_cnt), 64'd2);

        // Capture disabled: nothing pushed, nothing dropped
        ifc.trace_en = 1'b0;
        set_retire(32'h400, 32'h13, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        tick();
        clear_retire();
        tick();
        check_eq("dis_level", 64'(ifc.fifo_level), 64'd0);
        check_eq("dis_valid", 64'(ifc.tx_valid), 64'd0);
        check_eq("dis_drop_cnt", 64'(ifc.drop_cnt), 64'd2);
        ifc.trace_en = 1'b1;

        // Backpressure with tx_ready toggling over 3 records
        do_reset();
        ifc.tx_ready = 1'b0;
        set_retire(32'h100, 32'h00A00093, 1'b1, 5'd1, 32'hA, 1'b0, 32'd0);
        tick();
        set_retire(32'h104, 32'h0000A103, 1'b1, 5'd2, 32'hDEADBEEF, 1'b1, 32'h2000);
        tick();
        set_retire(32'h108, 32'h00000013, 1'b1, 5'd0, 32'h77, 1'b0, 32'd0);
        tick();
        clear_retire();
        stall_chk = 1'b1;
        for (int i = 0; i < 200; i++) begin
            ifc.tx_ready = ~ifc.tx_ready;
            tick();
            if (words.size() >= 12) break;
            if (words.size() > 0) check_eq("bp_no_gap", 64'(ifc.tx_valid), 64'd1);
        end
        stall_chk = 1'b0;
        ifc.tx_ready = 1'b1;
        wait_idle(50);
        ew(1'b0, 32'hA5008200); ew(1'b0, 32'h100); ew(1'b0, 32'h00A00093); ew(1'b1, 32'hA);
        ew(1'b0, 32'hA501C400); ew(1'b0, 32'h104); ew(1'b0, 32'h0000A103);
        ew(1'b0, 32'hDEADBEEF); ew(1'b1, 32'h2000);
        ew(1'b0, 32'hA5020000); ew(1'b0, 32'h108); ew(1'b1, 32'h00000013);
        check_words("bp");

        // 300 records: sequence number wraps
        do_reset();
        for (int r = 0; r < 300; r++) begin
            set_retire(32'(r * 4), 32'h13, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
            tick();
            clear_retire();
            tick(); tick(); tick();
        end
        wait_idle(50);
        check_eq("wrap_word_count", 64'(words.size()), 64'd900);
        if (words.size() == 900) begin
            check_eq("wrap_hdr255", 64'(words[765]), 64'({1'b0, 32'hA5FF0000}));
            check_eq("wrap_hdr256", 64'(words[768]), 64'({1'b0, 32'hA5000000}));
            check_eq("wrap_pc256", 64'(words[769]), 64'({1'b0, 32'h400}));
            check_eq("wrap_hdr299", 64'(words[897]), 64'({1'b0, 32'hA52B0000}));
        end
        check_eq("wrap_drop_cnt", 64'(ifc.drop_cnt), 64'd0);

        // Reset in the middle of a record with more queued behind it
        do_reset();
        set_retire(32'h500, 32'h13, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        tick();
        set_retire(32'h504, 32'h13, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        tick();
        set_retire(32'h508, 32'h13, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        tick();
        clear_retire();
        for (int i = 0; i < 20; i++) begin
            if (ifc.tx_valid && ifc.tx_data == 32'h500) break;
            tick();
        end
        check_eq("mid_at_pc_word", 64'(ifc.tx_data), 64'h500);
        rst = 1'b1;
        words.delete();
        tick();
        check_eq("mid_rst_valid", 64'(ifc.tx_valid), 64'd0);
        check_eq("mid_rst_level", 64'(ifc.fifo_level), 64'd0);
        check_eq("mid_rst_data", 64'(ifc.tx_data), 64'd0);
        rst = 1'b0;
        set_retire(32'h600, 32'h13, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        tick();
        clear_retire();
        wait_idle(50);
        ew(1'b0, 32'hA5000000); ew(1'b0, 32'h600); ew(1'b1, 32'h13);
        check_words("mid_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
